// File: rtl/uart_rx_buffered.sv
// 8N1 UART receiver with 2-flop synchroniser, 3-sample majority voting,
// framing-error accounting and a small valid/ready FIFO on the output.
module uart_rx_buffered #(
  parameter int unsigned CLKS_PER_BIT = 100,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic                          clk_50M,
  input  logic                          rst_n,
  input  logic                          uart_rx_pin,
  output logic [7:0]                    rx_byte,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   rx_level,
  output logic                          frame_err_pulse,
  output logic [7:0]                    frame_err_count,
  output logic                          overflow,
  input  logic                          clear_errors
);
  localparam int unsigned CW   = $clog2(CLKS_PER_BIT);
  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned LW   = AW + 1;
  localparam int unsigned HALF = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] S0   = CW'(HALF - 1);
  localparam logic [CW-1:0] S1   = CW'(HALF);
  localparam logic [CW-1:0] S2   = CW'(HALF + 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  state_t        state_q, state_d;
  logic          meta_q, s_rx_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          v0_q, v0_d, v1_q, v1_d;
  logic          maj, at_mid, at_end, push, ferr;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [LW-1:0] level_q, level_d;
  logic          full, pop, wr_en, ovf_evt;
  logic [7:0]    ecnt_q, ecnt_d;
  logic          ovf_q, ovf_d, pulse_q;

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      s_rx_q <= 1'b1;
    end else begin
      meta_q <= uart_rx_pin;
      s_rx_q <= meta_q;
    end
  end

  // Third vote is the live s_rx at HALF+1; the first two are held.
  assign maj    = (v0_q & v1_q) | (v0_q & s_rx_q) | (v1_q & s_rx_q);
  assign at_mid = (cnt_q == S2);
  assign at_end = (cnt_q == LAST);

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      v0_q    <= 1'b1;
      v1_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      v0_q    <= v0_d;
      v1_q    <= v1_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    v0_d    = v0_q;
    v1_d    = v1_q;
    push    = 1'b0;
    ferr    = 1'b0;
    if (cnt_q == S0) v0_d = s_rx_q;
    if (cnt_q == S1) v1_d = s_rx_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (!s_rx_q) state_d = START;
      end
      START: begin
        if (at_mid && maj) begin
          state_d = IDLE;
        end else if (at_end) begin
          cnt_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (at_mid) shift_d = {maj, shift_q[7:1]};
        if (at_end) begin
          cnt_d = '0;
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (at_mid) begin
          if (maj) begin
            push    = 1'b1;
            state_d = IDLE;
          end else begin
            ferr    = 1'b1;
            state_d = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (s_rx_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A pop in the same clock frees the slot, so a full FIFO still accepts.
  assign full    = (level_q == LW'(FIFO_DEPTH));
  assign pop     = rx_valid & rx_ready;
  assign wr_en   = push & (~full | pop);
  assign ovf_evt = push & full & ~pop;

  always_ff @(posedge clk_50M) begin
    if (wr_en) mem_q[wr_q] <= shift_q;
  end

  always_comb begin
    level_d = level_q;
    if (wr_en && !pop)      level_d = level_q + LW'(1);
    else if (!wr_en && pop) level_d = level_q - LW'(1);
  end

  always_comb begin
    ecnt_d = ecnt_q;
    ovf_d  = ovf_q;
    if (clear_errors) begin
      ecnt_d = '0;
      ovf_d  = 1'b0;
    end
    if (ferr) ecnt_d = clear_errors ? 8'd1 : ((ecnt_q == 8'hFF) ? ecnt_q : ecnt_q + 8'd1);
    if (ovf_evt) ovf_d = 1'b1;
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      ecnt_q  <= '0;
      ovf_q   <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      if (wr_en) wr_q <= wr_q + AW'(1);
      if (pop)   rd_q <= rd_q + AW'(1);
      level_q <= level_d;
      ecnt_q  <= ecnt_d;
      ovf_q   <= ovf_d;
      pulse_q <= ferr;
    end
  end

  assign rx_valid        = (level_q != '0);
  assign rx_byte         = rx_valid ? mem_q[rd_q] : '0;
  assign rx_level        = level_q;
  assign frame_err_pulse = pulse_q;
  assign frame_err_count = ecnt_q;
  assign overflow        = ovf_q;

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Directed bench for uart_rx_buffered: frame table plus timing-exact
// sequences for overflow, simultaneous push/pop, error clearing and reset.
module tb_uart_rx_buffered;
  localparam int CPB      = 100;
  localparam int DEPTH    = 16;
  localparam int SPIKE_AT = 50;
  localparam int PUSH_CYC = 954;

  logic       clk_50M = 1'b0;
  logic       rst_n = 1'b0;
  logic       uart_rx_pin = 1'b1;
  logic       rx_ready = 1'b0;
  logic       clear_errors = 1'b0;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic [4:0] rx_level;
  logic       frame_err_pulse;
  logic [7:0] frame_err_count;
  logic       overflow;

  uart_rx_buffered #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk_50M(clk_50M), .rst_n(rst_n), .uart_rx_pin(uart_rx_pin),
    .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_level(rx_level), .frame_err_pulse(frame_err_pulse),
    .frame_err_count(frame_err_count), .overflow(overflow),
    .clear_errors(clear_errors)
  );

  always #10 clk_50M = ~clk_50M;

  logic [7:0] got_q[$];
  int         err_pulses = 0;

  always begin
    @(negedge clk_50M);
    #1;
    if (rst_n && rx_valid && rx_ready) got_q.push_back(rx_byte);
    if (frame_err_pulse) err_pulses++;
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int spike);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < CPB; c++) begin
        uart_rx_pin = (b == spike && c == SPIKE_AT) ? ~bits[b] : bits[b];
        @(negedge clk_50M);
      end
    end
  endtask

  task automatic idle(input int n);
    uart_rx_pin = 1'b1;
    repeat (n) @(negedge clk_50M);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         spike;
    int         exp_bytes;
    int         exp_cnt;
  } vec_t;

  vec_t vecs[7];
  int   base, pbase, lat;

  initial begin
    vecs[0] = '{8'h5A, 1'b1, -1, 1, 1};
    vecs[1] = '{8'h00, 1'b1, -1, 1, 1};
    vecs[2] = '{8'hFF, 1'b1, -1, 1, 1};
    vecs[3] = '{8'h81, 1'b1,  4, 1, 1};
    vecs[4] = '{8'h7E, 1'b1,  2, 1, 1};
    vecs[5] = '{8'hC3, 1'b0, -1, 0, 2};
    vecs[6] = '{8'h96, 1'b1, -1, 1, 2};

    repeat (3) @(negedge clk_50M);
    rst_n = 1'b1;
    @(negedge clk_50M);
    #1;
    chk("rst_valid", int'(rx_valid), 0);
    chk("rst_level", int'(rx_level), 0);
    chk("rst_byte", int'(rx_byte), 0);
    chk("rst_pulse", int'(frame_err_pulse), 0);
    chk("rst_errcnt", int'(frame_err_count), 0);
    chk("rst_overflow", int'(overflow), 0);

    // Single byte with latency measurement
    rx_ready = 1'b1;
    idle(20);
    base = got_q.size();
    lat = 0;
    fork
      send_frame(8'hA5, 1'b1, -1);
      begin
        for (int n = 1; n <= 2000; n++) begin
          @(negedge clk_50M);
          #1;
          if (rx_valid) begin
            lat = n;
            break;
          end
        end
        chk("a5_latency_953_956", int'(lat >= 953 && lat <= 956), 1);
        chk("a5_byte_at_valid", int'(rx_byte), 8'hA5);
        @(negedge clk_50M);
        #1;
        chk("a5_valid_one_cycle", int'(rx_valid), 0);
      end
    join
    idle(100);
    chk("a5_count", got_q.size() - base, 1);
    if (got_q.size() > base) chk("a5_data", int'(got_q[base]), 8'hA5);
    chk("a5_level", int'(rx_level), 0);

    // 30-clock glitch on idle line
    base = got_q.size();
    pbase = err_pulses;
    uart_rx_pin = 1'b0;
    repeat (30) @(negedge clk_50M);
    idle(1500);
    chk("glitch_nobyte", got_q.size() - base, 0);
    chk("glitch_nopulse", err_pulses - pbase, 0);
    chk("glitch_errcnt", int'(frame_err_count), 0);

    // Framing error, line break, recovery
    base = got_q.size();
    pbase = err_pulses;
    send_frame(8'h3C, 1'b0, -1);
    repeat (2000) @(negedge clk_50M);
    idle(50);
    send_frame(8'h11, 1'b1, -1);
    idle(200);
    chk("ferr_pulses", err_pulses - pbase, 1);
    chk("ferr_count", int'(frame_err_count), 1);
    chk("ferr_bytes", got_q.size() - base, 1);
    if (got_q.size() > base) chk("ferr_next_byte", int'(got_q[base]), 8'h11);

    // Frame table
    for (int i = 0; i < 7; i++) begin
      base = got_q.size();
      pbase = err_pulses;
      send_frame(vecs[i].data, vecs[i].stop, vecs[i].spike);
      idle(300);
      chk($sformatf("vec%0d_nbytes", i), got_q.size() - base, vecs[i].exp_bytes);
      if (vecs[i].exp_bytes == 1 && got_q.size() > base)
        chk($sformatf("vec%0d_data", i), int'(got_q[base]), int'(vecs[i].data));
      chk($sformatf("vec%0d_errcnt", i), int'(frame_err_count), vecs[i].exp_cnt);
      chk($sformatf("vec%0d_pulses", i), err_pulses - pbase, vecs[i].stop ? 0 : 1);
    end

    // Framing error coinciding with clear_errors: count restarts at 1
    @(negedge clk_50M);
    fork
      send_frame(8'h44, 1'b0, -1);
      begin
        repeat (PUSH_CYC) @(negedge clk_50M);
        clear_errors = 1'b1;
        @(negedge clk_50M);
        clear_errors = 1'b0;
      end
    join
    idle(300);
    chk("clr_ferr_count", int'(frame_err_count), 1);

    // 17 back-to-back bytes into a stalled FIFO; clear on the overflow clock
    rx_ready = 1'b0;
    @(negedge clk_50M);
    fork
      for (int i = 0; i < 17; i++) send_frame(8'(i), 1'b1, -1);
      begin
        repeat (16 * 1000 + PUSH_CYC) @(negedge clk_50M);
        clear_errors = 1'b1;
        @(negedge clk_50M);
        clear_errors = 1'b0;
      end
    join
    idle(200);
    #1;
    chk("ovf_level", int'(rx_level), 16);
    chk("ovf_flag_wins_clear", int'(overflow), 1);
    chk("ovf_errcnt_cleared", int'(frame_err_count), 0);
    @(negedge clk_50M);
    base = got_q.size();
    rx_ready = 1'b1;
    repeat (16) @(negedge clk_50M);
    #2;
    chk("drain_level", int'(rx_level), 0);
    chk("drain_count", got_q.size() - base, 16);
    for (int i = 0; i < 16; i++)
      if (got_q.size() > base + i) chk($sformatf("drain_%0d", i), int'(got_q[base + i]), i);
    @(negedge clk_50M);
    clear_errors = 1'b1;
    @(negedge clk_50M);
    clear_errors = 1'b0;
    #1;
    chk("clear_overflow", int'(overflow), 0);

    // Push and pop on the same clock while full
    rx_ready = 1'b0;
    @(negedge clk_50M);
    for (int i = 0; i < 16; i++) send_frame(8'h20 + 8'(i), 1'b1, -1);
    idle(200);
    #1;
    chk("full_level", int'(rx_level), 16);
    @(negedge clk_50M);
    base = got_q.size();
    fork
      send_frame(8'h30, 1'b1, -1);
      begin
        repeat (PUSH_CYC) @(negedge clk_50M);
        rx_ready = 1'b1;
        @(negedge clk_50M);
        rx_ready = 1'b0;
      end
    join
    idle(100);
    #1;
    chk("pp_level", int'(rx_level), 16);
    chk("pp_overflow", int'(overflow), 0);
    chk("pp_popped", got_q.size() - base, 1);
    if (got_q.size() > base) chk("pp_popped_data", int'(got_q[base]), 8'h20);
    @(negedge clk_50M);
    base = got_q.size();
    rx_ready = 1'b1;
    repeat (16) @(negedge clk_50M);
    #2;
    chk("pp_drain_level", int'(rx_level), 0);
    chk("pp_drain_count", got_q.size() - base, 16);
    if (got_q.size() >= base + 16) begin
      chk("pp_drain_first", int'(got_q[base]), 8'h21);
      chk("pp_drain_last", int'(got_q[base + 15]), 8'h30);
    end

    // Reset during data bit 4 of 0xFF with a byte already buffered
    @(negedge clk_50M);
    rx_ready = 1'b0;
    send_frame(8'h77, 1'b1, -1);
    idle(100);
    chk("pre_rst_level", int'(rx_level), 1);
    fork
      send_frame(8'hFF, 1'b1, -1);
      begin
        repeat (550) @(negedge clk_50M);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", int'(rx_valid), 0);
        chk("mid_rst_level", int'(rx_level), 0);
        chk("mid_rst_byte", int'(rx_byte), 0);
        chk("mid_rst_pulse", int'(frame_err_pulse), 0);
        chk("mid_rst_errcnt", int'(frame_err_count), 0);
        chk("mid_rst_overflow", int'(overflow), 0);
        repeat (3) @(negedge clk_50M);
        rst_n = 1'b1;
      end
    join
    base = got_q.size();
    rx_ready = 1'b1;
    idle(300);
    chk("post_rst_nobyte", got_q.size() - base, 0);
    chk("post_rst_level", int'(rx_level), 0);
    send_frame(8'h5A, 1'b1, -1);
    idle(300);
    chk("post_rst_count", got_q.size() - base, 1);
    if (got_q.size() > base) chk("post_rst_data", int'(got_q[base]), 8'h5A);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_buffered.md
# uart_rx_buffered

Upstream receive stage for the UART command controller. It turns the raw `uart_rx_pin` line into validated bytes and buffers them in a small FIFO, so the controller can consume them through a valid/ready handshake. The line is synchronised and majority-sampled. Framing errors and FIFO overflow are reported through counters and flags. Frame format is 8N1, LSB first, idle high; at 50 MHz the default rate is 500 kbps.

## Interface
- `CLKS_PER_BIT`, default 100: clocks per bit. Must be ≥ 8 and even.
- `FIFO_DEPTH`, default 16: FIFO entries. Power of two, ≥ 2.
- `clk_50M`  in  1  system clock; all logic is on its rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low. One clock; reset is asynchronous and active-low.
- `uart_rx_pin`  in  1  raw serial line, asynchronous to `clk_50M`.
- `rx_byte`  out  8  byte at the FIFO head; valid only while `rx_valid` = 1.
- `rx_valid`  out  1  FIFO non-empty.
- `rx_ready`  in  1  consumer accepts `rx_byte`; the pop happens on a clock where `rx_valid && rx_ready`.
- `rx_level`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- `frame_err_pulse`  out  1  one-cycle pulse for each frame that fails its stop bit.
- `frame_err_count`  out  8  saturating count of framing errors.
- `overflow`  out  1  sticky flag: a byte was dropped because the FIFO was full.
- `clear_errors`  in  1  synchronous clear of `frame_err_count` and `overflow`.

## Operation
- **Synchroniser:** two flops; reset value 1. `s_rx` is the second flop output. All logic uses only `s_rx`.
- **Sampling:** `HALF` = `CLKS_PER_BIT/2`. In each bit cell, `s_rx` is sampled at cell counts `HALF-1`, `HALF` and `HALF+1`. The bit value is the 2-of-3 majority.
- **FSM states:** IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: waits for `s_rx` = 0. On that clock, clear the cell counter and go to START.
  - START: evaluates the majority at count `HALF+1`.
    - Majority 1: glitch; return to IDLE.
    - Majority 0: continue to the end of the cell, then go to DATA.
    - The cell counter wraps at `CLKS_PER_BIT-1`.
  - DATA: 8 cells. Each majority bit is shifted in at bit index 0..7, LSB first. After cell 7 ends, go to STOP.
  - STOP: majority taken at count `HALF+1`.
    - Majority 1: push the byte and go to IDLE immediately, so a back-to-back start bit is caught within the second half of the stop cell.
    - Majority 0: framing error. Pulse `frame_err_pulse`, increment `frame_err_count` (saturating at 255), discard the byte, go to WAIT_IDLE.
  - WAIT_IDLE: stays until `s_rx` = 1 for one clock, then goes to IDLE. This absorbs line breaks without producing bytes.
- **FIFO:** `FIFO_DEPTH` entries with read and write pointers. Occupancy is tracked in `rx_level`.
  - Push when full: the byte is dropped, `overflow` is set, and FIFO contents are unchanged.
  - Push and pop on the same clock while full: the pop frees a slot, so the push succeeds. No overflow; level unchanged.
  - Push and pop on the same clock while empty: the push lands; the pop is ignored because `rx_valid` was 0.
- **Outputs:** `rx_byte` is driven from FIFO memory at the read pointer; there is no fall-through latency beyond one registered write.
- **Clearing errors:** `clear_errors` clears `frame_err_count` and `overflow`. If a new error occurs on the same clock, the error wins:
  - count becomes 1;
  - `overflow` stays 1.
- **Reset values:**
  - FSM = IDLE;
  - FIFO empty: `rx_valid` = 0, `rx_level` = 0;
  - `rx_byte` = 0;
  - `frame_err_pulse` = 0, `frame_err_count` = 0;
  - `overflow` = 0.
- **Reset mid-frame:** the partial byte is discarded. After reset, reception resumes at the next falling edge of the synchronised line.

## Timing
- Falling edge on `uart_rx_pin` to FSM leaving IDLE: 2–3 clocks (synchroniser).
- Push occurs at stop-cell count `HALF+1`. `rx_valid` rises on the next clock.
- **Pop:** on a clock with `rx_valid && rx_ready`, the head advances at that edge. The next byte, if any, is visible on the following cycle.
- Consumer holding `rx_ready` = 1: each byte produces a one-cycle `rx_valid` pulse. This is compatible with a pulse-style consumer.
- `frame_err_pulse` is exactly one clock wide, in the clock after the stop majority is evaluated.
- **Frame rates:** with the default parameters one frame takes 1000 clocks. Worst-case tolerated rate mismatch is ±4% (defined by the mid-cell sampling).

## Test plan
- **Single byte:** drive 0xA5 at 100 clk/bit with `rx_ready` = 1. Require:
  - one `rx_valid` pulse with `rx_byte` = 0xA5;
  - rise between 953 and 956 clocks after the start-bit edge;
  - `rx_level` returns to 0.
- **Glitch rejection:** a 30-clock low pulse on an idle line gives no `rx_valid` and no error. A 1-clock low spike inside a data bit is majority-filtered, and the byte arrives intact.
- **Framing error:** send 0x3C with stop bit = 0, then hold low for 2000 clocks, then send 0x11. Require:
  - `frame_err_pulse` pulses once and `frame_err_count` = 1;
  - 0x3C is not delivered;
  - 0x11 is delivered.
- **Buffering and overflow:** with `rx_ready` = 0, send 17 bytes 0x00..0x10 back-to-back. Require:
  - `rx_level` = 16 and `overflow` = 1;
  - then raise `rx_ready`: 0x00..0x0F drain in order, one per clock, and 0x10 is absent.
- **Simultaneous push and pop:** with the FIFO full, hold `rx_ready` = 1 on the push clock. The push succeeds, `overflow` stays 0 and `rx_level` stays 16. Separately, with `clear_errors` and an overflow on the same clock, `overflow` must remain 1.
- **Reset mid-frame:** assert `rst_n` low during data bit 4 of 0xFF, then release it. Require:
  - all outputs at their reset values;
  - no byte delivered;
  - a following 0x5A is received correctly.
